// File: rtl/mmio_gpio_bank.sv
// Memory-mapped GPIO bank: NUM_CH output words with SET/CLR/TOG aliases, one synchronised
// input word with sticky rising-edge status (write-1-to-clear) and a maskable interrupt.
module mmio_gpio_bank #(
   parameter int                      DATA_WIDTH  = 32,
   parameter int                      ADDR_WIDTH  = 10,
   parameter int                      NUM_CH      = 2,
   parameter int                      SYNC_STAGES = 2,
   parameter logic [DATA_WIDTH-1:0]   OUT_RESET   = '0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         sel,
   input  logic                         re,
   input  logic                         we,
   input  logic [DATA_WIDTH/8-1:0]      byteEn,
   input  logic [ADDR_WIDTH-1:0]        addr,
   input  logic [DATA_WIDTH-1:0]        wdata,
   output logic [DATA_WIDTH-1:0]        rdata,
   output logic                         rvalid,
   output logic [NUM_CH*DATA_WIDTH-1:0] gpo,
   input  logic [DATA_WIDTH-1:0]        gpi,
   output logic                         irq
);

   localparam int NB     = DATA_WIDTH / 8;
   localparam int IN_OFF = 4 * NUM_CH;

   logic [31:0]            wordIdx;
   logic                   wrEn;
   logic                   rdEn;
   logic [DATA_WIDTH-1:0]  laneMask;
   logic [DATA_WIDTH-1:0]  outReg   [NUM_CH];
   logic [DATA_WIDTH-1:0]  outNext  [NUM_CH];
   logic [DATA_WIDTH-1:0]  syncChain[SYNC_STAGES];
   logic [DATA_WIDTH-1:0]  inWord;
   logic [DATA_WIDTH-1:0]  prevIn;
   logic [DATA_WIDTH-1:0]  rise;
   logic [DATA_WIDTH-1:0]  edgeReg;
   logic [DATA_WIDTH-1:0]  edgeNext;
   logic [DATA_WIDTH-1:0]  irqEn;
   logic [DATA_WIDTH-1:0]  irqEnNext;
   logic [DATA_WIDTH-1:0]  rdNext;
   logic                   unusedAddrBits;

   assign unusedAddrBits = ^addr[1:0];
   assign wordIdx = 32'(addr[ADDR_WIDTH-1:2]);
   assign wrEn    = sel & we;
   assign rdEn    = sel & re;
   assign inWord  = syncChain[SYNC_STAGES-1];
   assign rise    = inWord & ~prevIn;

   always_comb begin
      laneMask = '0;
      for (int b = 0; b < NB; b++)
         laneMask[b*8 +: 8] = {8{byteEn[b]}};
   end

   always_comb begin
      logic [DATA_WIDTH-1:0] cand;
      for (int c = 0; c < NUM_CH; c++) begin
         outNext[c] = outReg[c];
         cand       = outReg[c];
         if (wrEn && wordIdx[31:2] == 30'(c)) begin
            case (wordIdx[1:0])
               2'd0:    cand = wdata;
               2'd1:    cand = outReg[c] | wdata;
               2'd2:    cand = outReg[c] & ~wdata;
               default: cand = outReg[c] ^ wdata;
            endcase
            outNext[c] = (cand & laneMask) | (outReg[c] & ~laneMask);
         end
      end
   end

   // Clear is applied first so a rise landing in the same cycle wins.
   always_comb begin
      edgeNext  = edgeReg;
      irqEnNext = irqEn;
      if (wrEn && wordIdx == 32'(IN_OFF + 1))
         edgeNext = edgeReg & ~(wdata & laneMask);
      if (wrEn && wordIdx == 32'(IN_OFF + 2))
         irqEnNext = (wdata & laneMask) | (irqEn & ~laneMask);
      edgeNext = edgeNext | rise;
   end

   always_comb begin
      rdNext = '0;
      for (int c = 0; c < NUM_CH; c++)
         if (wordIdx[31:2] == 30'(c))
            rdNext = outReg[c];
      if (wordIdx == 32'(IN_OFF))
         rdNext = inWord;
      else if (wordIdx == 32'(IN_OFF + 1))
         rdNext = edgeReg;
      else if (wordIdx == 32'(IN_OFF + 2))
         rdNext = irqEn;
   end

   always_comb begin
      gpo = '0;
      for (int c = 0; c < NUM_CH; c++)
         gpo[c*DATA_WIDTH +: DATA_WIDTH] = outReg[c];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int c = 0; c < NUM_CH; c++)
            outReg[c] <= OUT_RESET;
         for (int s = 0; s < SYNC_STAGES; s++)
            syncChain[s] <= '0;
         prevIn  <= '0;
         edgeReg <= '0;
         irqEn   <= '0;
         irq     <= 1'b0;
         rdata   <= '0;
         rvalid  <= 1'b0;
      end else begin
         for (int c = 0; c < NUM_CH; c++)
            outReg[c] <= outNext[c];
         syncChain[0] <= gpi;
         for (int s = 1; s < SYNC_STAGES; s++)
            syncChain[s] <= syncChain[s-1];
         prevIn  <= inWord;
         edgeReg <= edgeNext;
         irqEn   <= irqEnNext;
         irq     <= |(edgeReg & irqEn);
         rvalid  <= rdEn;
         if (rdEn)
            rdata <= rdNext;
      end
   end

endmodule

// File: tb/tb_mmio_gpio_bank.sv
// Directed bench for mmio_gpio_bank: a vector table for register access plus hand-written
// sequences for same-cycle read/write, edge capture, set-beats-clear and reset mid-read.
module tb_mmio_gpio_bank;

   logic        clk = 1'b0;
   logic        rst;
   logic        sel;
   logic        re;
   logic        we;
   logic [3:0]  byteEn;
   logic [9:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        rvalid;
   logic [63:0] gpo;
   logic [31:0] gpi;
   logic        irq;

   int nTests = 0;
   int nFail  = 0;

   mmio_gpio_bank #(
      .DATA_WIDTH(32), .ADDR_WIDTH(10), .NUM_CH(2), .SYNC_STAGES(2), .OUT_RESET('0)
   ) dut (
      .clk(clk), .rst(rst), .sel(sel), .re(re), .we(we), .byteEn(byteEn),
      .addr(addr), .wdata(wdata), .rdata(rdata), .rvalid(rvalid),
      .gpo(gpo), .gpi(gpi), .irq(irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        isRd;
      logic [9:0]  a;
      logic [3:0]  be;
      logic [31:0] d;
      int          kind;   // 0: rdata, 1: gpo word 0, 2: gpo word 1
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[17];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nTests++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic busCycle(input logic r, input logic w, input logic [9:0] a,
                           input logic [3:0] b, input logic [31:0] d);
      @(negedge clk);
      sel = 1'b1; re = r; we = w; addr = a; byteEn = b; wdata = d;
      @(posedge clk);
      #1;
      sel = 1'b0; re = 1'b0; we = 1'b0;
   endtask

   initial begin
      vecs[0]  = '{1'b0, 10'h000, 4'b0101, 32'hA5A5_1234, 1, 32'h00A5_0034};
      vecs[1]  = '{1'b0, 10'h010, 4'hF,    32'h0000_00F0, 2, 32'h0000_00F0};
      vecs[2]  = '{1'b0, 10'h014, 4'hF,    32'h0000_000F, 2, 32'h0000_00FF};
      vecs[3]  = '{1'b0, 10'h018, 4'hF,    32'h0000_0030, 2, 32'h0000_00CF};
      vecs[4]  = '{1'b0, 10'h01C, 4'hF,    32'h0000_0081, 2, 32'h0000_004E};
      vecs[5]  = '{1'b1, 10'h010, 4'h0,    32'h0,         0, 32'h0000_004E};
      vecs[6]  = '{1'b1, 10'h014, 4'h0,    32'h0,         0, 32'h0000_004E};
      vecs[7]  = '{1'b1, 10'h01C, 4'h0,    32'h0,         0, 32'h0000_004E};
      vecs[8]  = '{1'b1, 10'h000, 4'h0,    32'h0,         0, 32'h00A5_0034};
      vecs[9]  = '{1'b0, 10'h028, 4'hF,    32'h0000_0008, 2, 32'h0000_004E};
      vecs[10] = '{1'b1, 10'h028, 4'h0,    32'h0,         0, 32'h0000_0008};
      vecs[11] = '{1'b1, 10'h3FC, 4'h0,    32'h0,         0, 32'h0000_0000};
      vecs[12] = '{1'b0, 10'h3FC, 4'hF,    32'hFFFF_FFFF, 1, 32'h00A5_0034};
      vecs[13] = '{1'b1, 10'h02C, 4'h0,    32'h0,         0, 32'h0000_0000};
      vecs[14] = '{1'b0, 10'h008, 4'b0100, 32'hFFFF_FFFF, 1, 32'h0000_0034};
      vecs[15] = '{1'b0, 10'h00C, 4'b0011, 32'h0000_FFFF, 1, 32'h0000_FFCB};
      vecs[16] = '{1'b1, 10'h00C, 4'h0,    32'h0,         0, 32'h0000_FFCB};

      rst = 1'b1; sel = 1'b0; re = 1'b0; we = 1'b0;
      byteEn = '0; addr = '0; wdata = '0; gpi = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("reset gpo0", gpo[31:0], 32'h0);
      check("reset gpo1", gpo[63:32], 32'h0);
      check("reset rdata", rdata, 32'h0);
      check("reset rvalid", {31'b0, rvalid}, 32'h0);
      check("reset irq", {31'b0, irq}, 32'h0);

      for (int i = 0; i < 17; i++) begin
         busCycle(vecs[i].isRd, ~vecs[i].isRd, vecs[i].a, vecs[i].be, vecs[i].d);
         case (vecs[i].kind)
            0: begin
               check($sformatf("vec%0d rvalid", i), {31'b0, rvalid}, 32'h1);
               check($sformatf("vec%0d rdata", i), rdata, vecs[i].exp);
            end
            1: check($sformatf("vec%0d gpo0", i), gpo[31:0], vecs[i].exp);
            default: check($sformatf("vec%0d gpo1", i), gpo[63:32], vecs[i].exp);
         endcase
      end
      check("gpo1 after unmapped write", gpo[63:32], 32'h0000_004E);

      // Same-cycle read and write return the old value.
      busCycle(1'b0, 1'b1, 10'h000, 4'hF, 32'h0000_0011);
      busCycle(1'b1, 1'b1, 10'h000, 4'hF, 32'h0000_0022);
      check("rw rvalid", {31'b0, rvalid}, 32'h1);
      check("rw rdata old", rdata, 32'h0000_0011);
      check("rw gpo0 new", gpo[31:0], 32'h0000_0022);
      busCycle(1'b1, 1'b0, 10'h000, 4'h0, 32'h0);
      check("rw reread", rdata, 32'h0000_0022);
      tick();
      check("idle rvalid", {31'b0, rvalid}, 32'h0);
      check("idle rdata hold", rdata, 32'h0000_0022);

      // gpi[3] rise with IRQEN=0x8: EDGE after 3 edges, irq after 4.
      @(negedge clk);
      gpi[3] = 1'b1;
      tick(); tick(); tick();
      check("irq before edge visible", {31'b0, irq}, 32'h0);
      tick();
      check("irq asserted", {31'b0, irq}, 32'h1);
      busCycle(1'b1, 1'b0, 10'h020, 4'h0, 32'h0);
      check("IN read", rdata, 32'h0000_0008);
      busCycle(1'b1, 1'b0, 10'h024, 4'h0, 32'h0);
      check("EDGE read", rdata, 32'h0000_0008);
      busCycle(1'b0, 1'b1, 10'h024, 4'hF, 32'h0000_0008);
      check("irq lags W1C", {31'b0, irq}, 32'h1);
      tick();
      check("irq cleared", {31'b0, irq}, 32'h0);
      busCycle(1'b1, 1'b0, 10'h024, 4'h0, 32'h0);
      check("EDGE after W1C", rdata, 32'h0);

      // W1C of EDGE[0] on the same edge its rise is captured: set wins.
      @(negedge clk);
      gpi[0] = 1'b1;
      tick(); tick();
      busCycle(1'b0, 1'b1, 10'h024, 4'hF, 32'h0000_0001);
      busCycle(1'b1, 1'b0, 10'h024, 4'h0, 32'h0);
      check("set beats clear", rdata, 32'h0000_0001);

      // Enable bit 0 to raise irq, then reset during a read.
      busCycle(1'b0, 1'b1, 10'h028, 4'hF, 32'h0000_0001);
      tick();
      check("irq before reset", {31'b0, irq}, 32'h1);
      @(negedge clk);
      sel = 1'b1; re = 1'b1; addr = 10'h000; rst = 1'b1;
      @(posedge clk);
      #1;
      sel = 1'b0; re = 1'b0; rst = 1'b0;
      check("rst rvalid", {31'b0, rvalid}, 32'h0);
      check("rst rdata", rdata, 32'h0);
      check("rst gpo0", gpo[31:0], 32'h0);
      check("rst gpo1", gpo[63:32], 32'h0);
      check("rst irq", {31'b0, irq}, 32'h0);
      busCycle(1'b1, 1'b0, 10'h028, 4'h0, 32'h0);
      check("rst IRQEN", rdata, 32'h0);
      tick(); tick();
      busCycle(1'b1, 1'b0, 10'h024, 4'h0, 32'h0);
      check("post-reset rise", rdata, 32'h0000_0009);

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
